exe_md_ctrl: RTL and testbench

Sequencer for the multiply/divide datapath in the EXE stage. It accepts one mul.w/mulh.w/mulh.wu/div.w/mod.w/div.wu/mod.wu operation, taken from ALU op bits [18:12], with its two operands.
- Multiplies run on a registered 32x32 multiplier.
- Divides run on a 32-iteration radix-2 restoring divider.
- The result and destination tag are held until EXE accepts them.
EXE stalls its ready_go while this block is busy. WB-stage flush (exception/ertn) aborts the operation in progress.

---
 rtl/exe_md_ctrl.sv | 132 +++++++++++++
 tb/tb_exe_md_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/exe_md_ctrl.sv
// Multiply/divide sequencer for the EXE stage: one-cycle registered multiply and
// 32-step restoring divide. The result is held until EXE takes it.
module exe_md_ctrl #(
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       md_op,
   input  logic [31:0]      src1,
   input  logic [31:0]      src2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      result,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

   state_t      state;
   logic [4:0]  cnt;
   logic        a_neg, b_neg, mul_hi, quo_sel;
   logic [31:0] rem, quo, dvs;

   logic [6:0]  op_sel;
   logic        is_mul, is_sgn, accept;
   logic [31:0] abs1, abs2;
   logic [63:0] prod, prod_s;
   logic [32:0] shifted, diff;
   logic [31:0] q_fix, r_fix;

   assign in_ready = (state == S_IDLE) & ~reset & ~flush;
   assign busy     = (state != S_IDLE);

   // Isolate the lowest set bit so a multi-hot op decodes deterministically.
   assign op_sel = md_op & (~md_op + 7'd1);
   assign is_mul = |op_sel[2:0];
   assign is_sgn = op_sel[0] | op_sel[1] | op_sel[3] | op_sel[4];
   assign accept = in_valid & in_ready & (|md_op);

   // abs(0x80000000) stays 0x80000000 and is used as an unsigned magnitude.
   assign abs1 = (is_sgn & src1[31]) ? (~src1 + 32'd1) : src1;
   assign abs2 = (is_sgn & src2[31]) ? (~src2 + 32'd1) : src2;

   // quo doubles as the multiplicand register while in MUL.
   assign prod   = {32'd0, quo} * {32'd0, dvs};
   assign prod_s = (a_neg ^ b_neg) ? (~prod + 64'd1) : prod;

   assign shifted = {rem, quo[31]};
   assign diff    = shifted - {1'b0, dvs};

   assign q_fix = (a_neg ^ b_neg) ? (~quo + 32'd1) : quo;
   assign r_fix = a_neg ? (~rem + 32'd1) : rem;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         out_tag   <= '0;
         cnt       <= '0;
         a_neg     <= 1'b0;
         b_neg     <= 1'b0;
         mul_hi    <= 1'b0;
         quo_sel   <= 1'b0;
         rem       <= '0;
         quo       <= '0;
         dvs       <= '0;
      end else if (flush) begin
         state     <= S_IDLE;
         out_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  out_tag <= in_tag;
                  a_neg   <= is_sgn & src1[31];
                  b_neg   <= is_sgn & src2[31];
                  mul_hi  <= op_sel[1] | op_sel[2];
                  quo_sel <= op_sel[3] | op_sel[5];
                  rem     <= '0;
                  quo     <= abs1;
                  dvs     <= abs2;
                  cnt     <= '0;
                  if (is_mul) begin
                     state <= S_MUL;
                  end else if (src2 == 32'd0) begin
                     state     <= S_DONE;
                     out_valid <= 1'b1;
                     result    <= (op_sel[3] | op_sel[5]) ? 32'hFFFF_FFFF : src1;
                  end else begin
                     state <= S_DIV;
                  end
               end
            end
            S_MUL: begin
               result    <= mul_hi ? prod_s[63:32] : prod_s[31:0];
               state     <= S_DONE;
               out_valid <= 1'b1;
            end
            S_DIV: begin
               if (!diff[32]) begin
                  rem <= diff[31:0];
                  quo <= {quo[30:0], 1'b1};
               end else begin
                  rem <= shifted[31:0];
                  quo <= {quo[30:0], 1'b0};
               end
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) state <= S_FIX;
            end
            S_FIX: begin
               result    <= quo_sel ? q_fix : r_fix;
               state     <= S_DONE;
               out_valid <= 1'b1;
            end
            S_DONE: begin
               if (out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exe_md_ctrl.sv
// Directed and random checks for exe_md_ctrl, with expectations queued in a scoreboard.
module tb_exe_md_ctrl;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic [6:0]  md_op;
   logic [31:0] src1, src2;
   logic [4:0]  in_tag;
   logic        in_ready, out_valid, busy;
   logic [31:0] result;
   logic [4:0]  out_tag;

   int vectors = 0;
   int miscompares = 0;
   logic [36:0] sb_q[$];

   exe_md_ctrl #(.TAG_W(5)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .md_op(md_op), .src1(src1), .src2(src2), .in_tag(in_tag), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .out_tag(out_tag), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input int k, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      logic [63:0] p;
      sa = $signed(a);
      sb = $signed(b);
      case (k)
         0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
         1: begin p = sa * sb; return p[63:32]; end
         2: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         3: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
         4: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
         5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Issue one op, check latency/busy, pop the scoreboard on out_valid, optionally stall.
   task automatic run_op(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] exp, input int lat,
                         input int hold);
      int n;
      logic all_busy;
      logic [36:0] e;
      logic [31:0] r0;
      sb_q.push_back({tag, exp});
      @(negedge clk);
      md_op = op; src1 = a; src2 = b; in_tag = tag; in_valid = 1'b1;
      chk("in_ready_idle", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0; md_op = 7'($urandom); src1 = $urandom; src2 = $urandom; in_tag = 5'($urandom);
      n = 1; all_busy = 1'b1;
      while (!out_valid && n < 200) begin
         if (!busy) all_busy = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      chk("latency", n, lat);
      chk("busy_during_op", all_busy, 1);
      e = sb_q.pop_front();
      chk("result", result, e[31:0]);
      chk("out_tag", out_tag, e[36:32]);
      r0 = result;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_result", result, r0);
         chk("hold_tag", out_tag, e[36:32]);
         chk("hold_in_ready", in_ready, 0);
         chk("hold_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("handoff_idle", busy, 0);
      chk("handoff_in_ready", in_ready, 1);
      chk("handoff_valid", out_valid, 0);
   endtask

   initial begin
      int k, lat, n;
      logic [31:0] a, b;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      md_op = '0; src1 = '0; src2 = '0; in_tag = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_tag", out_tag, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b0;

      // multiplies
      run_op(7'b0000001, 32'h0001_0001, 32'h0001_0001, 5'd1, 32'h0002_0001, 2, 0);
      run_op(7'b0000100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 2, 0);
      run_op(7'b0000010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0000, 2, 0);
      // signed divides
      run_op(7'b0001000, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 34, 0);
      run_op(7'b0010000, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF, 34, 0);
      // unsigned divides and signed overflow
      run_op(7'b0100000, 32'hFFFF_FFFF, 32'h10, 5'd6, 32'h0FFF_FFFF, 34, 0);
      run_op(7'b1000000, 32'hFFFF_FFFF, 32'h10, 5'd8, 32'h0000_000F, 34, 0);
      run_op(7'b0001000, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 34, 0);
      run_op(7'b0010000, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0000_0000, 34, 0);
      // divide by zero
      run_op(7'b0001000, 32'h1234, 32'd0, 5'd11, 32'hFFFF_FFFF, 1, 0);
      run_op(7'b1000000, 32'h1234, 32'd0, 5'd12, 32'h0000_1234, 1, 0);
      // stall in DONE, then multi-hot op (lowest bit = mul.w wins)
      run_op(7'b0000001, 32'd6, 32'd7, 5'd7, 32'd42, 2, 5);
      run_op(7'b0001001, 32'd9, 32'd3, 5'd13, 32'd27, 2, 0);

      // random ops against the reference model
      for (int i = 0; i < 8; i++) begin
         k = $urandom_range(0, 6);
         a = $urandom;
         b = (i == 3) ? 32'd0 : ((i % 2) ? 32'($urandom_range(1, 300)) : $urandom);
         lat = (k < 3) ? 2 : ((b == 0) ? 1 : 34);
         run_op(7'(1 << k), a, b, 5'(i + 16), model(k, a, b), lat, 0);
      end

      // md_op == 0 is ignored
      @(negedge clk);
      md_op = 7'd0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("zero_op_ignored", busy, 0);

      // flush at DIV counter 10
      @(negedge clk);
      md_op = 7'b0001000; src1 = 32'd1000; src2 = 32'd7; in_tag = 5'd20; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      flush = 1'b1;
      chk("pre_flush_busy", busy, 1);
      chk("flush_in_ready", in_ready, 0);
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_idle", busy, 0);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) n++;
         @(posedge clk); #1;
      end
      chk("flush_no_valid", n, 0);

      // flush coincident with in_valid in IDLE
      @(negedge clk);
      md_op = 7'b0000001; src1 = 32'd3; src2 = 32'd3; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      chk("flush_blocks_accept", busy, 0);

      // reset during MUL
      @(negedge clk);
      md_op = 7'b0000001; src1 = 32'd5; src2 = 32'd5; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("in_mul_busy", busy, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("reset_mul_idle", busy, 0);
      chk("reset_mul_valid", out_valid, 0);
      chk("reset_mul_result", result, 0);
      reset = 1'b0;

      // block still usable afterwards
      run_op(7'b0100000, 32'd100, 32'd7, 5'd30, 32'd14, 34, 0);
      chk("sb_empty", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
